// File: rtl/gen_imm_pipe.sv
// gen_imm_pipe: pipelined immediate generator for the operand collector.
// Extracts and sign-extends instruction immediates to XLEN bits and keeps
// per-warp EXTI prefix state that widens vector (IMM_V) immediates.
// One output register stage with ready/valid handshakes on both sides.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid_i      request valid
//   in_ready_o      request accepted when in_valid_i & in_ready_o
//   inst_i          instruction word
//   sel_i           immediate type select
//   wid_i           warp id of the request
//   ext_set_i       request is an EXTI prefix (produces no output)
//   ext_imm_i       prefix payload
//   flush_i         discard pending prefix of flush_wid_i
//   flush_wid_i     warp to flush
//   out_valid_o     result valid
//   out_ready_i     consumer ready
//   out_imm_o       generated immediate
//   out_wid_o       warp id of the result
//   out_ext_used_o  result consumed a prefix
module gen_imm_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_WARP = 8,
  parameter int unsigned WID_W    = 3,
  parameter int unsigned EXT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         inst_i,
  input  logic [3:0]          sel_i,
  input  logic [WID_W-1:0]    wid_i,
  input  logic                ext_set_i,
  input  logic [EXT_BITS-1:0] ext_imm_i,
  input  logic                flush_i,
  input  logic [WID_W-1:0]    flush_wid_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     out_imm_o,
  output logic [WID_W-1:0]    out_wid_o,
  output logic                out_ext_used_o
);

  typedef enum logic [3:0] {
    IMM_I   = 4'd0,
    IMM_S   = 4'd1,
    IMM_B   = 4'd2,
    IMM_U   = 4'd3,
    IMM_J   = 4'd4,
    IMM_Z   = 4'd5,
    IMM_2   = 4'd6,
    IMM_V   = 4'd7,
    IMM_L11 = 4'd8,
    IMM_S11 = 4'd9
  } imm_sel_e;

  logic [EXT_BITS-1:0] ext_reg [NUM_WARP];
  logic [NUM_WARP-1:0] ext_vld;

  logic                accept;
  logic                produce;
  logic [EXT_BITS-1:0] ext_cur;
  logic                ext_cur_vld;
  logic signed [31:0]  imm32;
  logic                ext_used;
  logic [XLEN-1:0]     imm_next;

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst_i[6:0];

  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign produce     = accept && !ext_set_i;
  assign ext_cur     = ext_reg[wid_i];
  assign ext_cur_vld = ext_vld[wid_i];

  // Every immediate fits in 32 signed bits, so decode once at 32 bits and
  // widen with a single signed cast to XLEN.
  always_comb begin
    imm32    = '0;
    ext_used = 1'b0;
    case (sel_i)
      IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      IMM_U:   imm32 = {inst_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      IMM_Z:   imm32 = {27'b0, inst_i[19:15]};
      IMM_2:   imm32 = {{27{inst_i[24]}}, inst_i[24:20]};
      IMM_V: begin
        if (ext_cur_vld) begin
          imm32    = {{(27-EXT_BITS){ext_cur[EXT_BITS-1]}}, ext_cur, inst_i[19:15]};
          ext_used = 1'b1;
        end else begin
          imm32 = {{27{inst_i[19]}}, inst_i[19:15]};
        end
      end
      IMM_L11: imm32 = {{21{inst_i[30]}}, inst_i[30:20]};
      IMM_S11: imm32 = {{21{inst_i[30]}}, inst_i[30:25], inst_i[11:7]};
      default: begin
        // Jalr-style target: bit0 dropped only for non-negative offsets.
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        if (!inst_i[31]) imm32[0] = 1'b0;
      end
    endcase
    imm_next = XLEN'(imm32);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o    <= 1'b0;
      out_imm_o      <= '0;
      out_wid_o      <= '0;
      out_ext_used_o <= 1'b0;
    end else if (produce) begin
      out_valid_o    <= 1'b1;
      out_imm_o      <= imm_next;
      out_wid_o      <= wid_i;
      out_ext_used_o <= ext_used;
    end else if (out_ready_i) begin
      out_valid_o    <= 1'b0;
    end
  end

  // Flush is applied last so it overrides a same-cycle prefix write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_vld <= '0;
      for (int unsigned i = 0; i < NUM_WARP; i++) ext_reg[i] <= '0;
    end else begin
      if (accept) begin
        if (ext_set_i) begin
          ext_reg[wid_i] <= ext_imm_i;
          ext_vld[wid_i] <= 1'b1;
        end else begin
          ext_vld[wid_i] <= 1'b0;
        end
      end
      if (flush_i) ext_vld[flush_wid_i] <= 1'b0;
    end
  end

endmodule
